// File: rtl/fetch_sequencer_pkg.sv
// Shared front-end definitions for the fetch sequencer.
//   NOP_INSTRUCTION : value presented on instruction_fetch while no real
//                     instruction has been fetched (addi x0, x0, 0)
//   fetch_state_t   : fetch controller state encoding
//   PC_INCREMENT    : byte distance between sequential instructions
package fetch_sequencer_pkg;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
  localparam int          PC_INCREMENT    = 4;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_pc_select.sv
// Next-PC priority mux for the fetch sequencer (purely combinational).
//   redirect_valid/redirect_target : branch/trap redirect, highest priority
//   jal_detected/jal_target        : JAL restart from decode
//   advance                        : held instruction consumed, step past it
//   inst_pc                        : PC of the instruction currently held
//   pc                             : current fetch PC (kept when nothing fires)
//   next_pc                        : PC to load next cycle
module fetch_sequencer_pc_select
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_target,
  input  logic                    jal_detected,
  input  logic [ADDRESS_BITS-1:0] jal_target,
  input  logic                    advance,
  input  logic [ADDRESS_BITS-1:0] inst_pc,
  input  logic [ADDRESS_BITS-1:0] pc,
  output logic [ADDRESS_BITS-1:0] next_pc
);

  // Targets are forced word aligned by clearing the two low bits.
  localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(3);

  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = redirect_target & ALIGN_MASK;
    end else if (jal_detected) begin
      next_pc = jal_target & ALIGN_MASK;
    end else if (advance) begin
      // Wraps modulo 2^ADDRESS_BITS.
      next_pc = inst_pc + ADDRESS_BITS'(PC_INCREMENT);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding request at
// a time to instruction memory and presents the fetched word to decode.
// Ports:
//   clock, reset                     : clock, synchronous active-high reset
//   stall                            : decode cannot take the held instruction
//   redirect_valid, redirect_target  : branch/trap redirect (highest priority)
//   JAL_detected, jal_target         : JAL restart from decode
//   imem_req_valid/addr/ready        : request handshake to instruction memory
//   imem_resp_valid/data             : response from instruction memory
//   instruction_fetch, inst_PC_fetch : held instruction and its PC
//   valid_fetch                      : held instruction is real
//
// state | meaning
// REQ   | request pending at pc
// WAIT  | request accepted, awaiting response
// HOLD  | instruction held on the outputs
// DRAIN | discard one in-flight response after a redirect
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                      DATA_WIDTH   = 32,
  parameter int                      ADDRESS_BITS = 20,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_target,
  input  logic                    JAL_detected,
  input  logic [ADDRESS_BITS-1:0] jal_target,
  output logic                    imem_req_valid,
  output logic [ADDRESS_BITS-1:0] imem_req_addr,
  input  logic                    imem_req_ready,
  input  logic                    imem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   imem_resp_data,
  output logic [DATA_WIDTH-1:0]   instruction_fetch,
  output logic [ADDRESS_BITS-1:0] inst_PC_fetch,
  output logic                    valid_fetch
);

  fetch_state_t            state;
  fetch_state_t            next_state;
  logic [ADDRESS_BITS-1:0] pc;
  logic [ADDRESS_BITS-1:0] req_pc;
  logic [ADDRESS_BITS-1:0] next_pc;
  logic                    redirect_taken;
  logic                    advance;
  logic                    accept;
  logic                    load_fetch;

  assign redirect_taken = redirect_valid | JAL_detected;
  assign advance        = (state == ST_HOLD) && !stall;

  fetch_sequencer_pc_select #(
    .ADDRESS_BITS (ADDRESS_BITS)
  ) u_pc_select (
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .jal_detected    (JAL_detected),
    .jal_target      (jal_target),
    .advance         (advance),
    .inst_pc         (inst_PC_fetch),
    .pc              (pc),
    .next_pc         (next_pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_REQ;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    imem_req_valid = 1'b0;
    imem_req_addr  = pc;
    valid_fetch    = 1'b0;
    accept         = 1'b0;
    load_fetch     = 1'b0;

    if (redirect_taken) begin
      // A response arriving in the redirect cycle is the in-flight one; it is
      // dropped here, so DRAIN is only entered while it is still outstanding.
      case (state)
        ST_WAIT, ST_DRAIN: next_state = imem_resp_valid ? ST_REQ : ST_DRAIN;
        default:           next_state = ST_REQ;
      endcase
    end else begin
      case (state)
        ST_REQ: begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            accept     = 1'b1;
            next_state = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            load_fetch = 1'b1;
            next_state = ST_HOLD;
          end
        end
        ST_HOLD: begin
          valid_fetch = 1'b1;
          if (!stall) begin
            // Instruction is consumed now, so the next fetch goes out at once.
            imem_req_valid = 1'b1;
            imem_req_addr  = next_pc;
            if (imem_req_ready) begin
              accept     = 1'b1;
              next_state = ST_WAIT;
            end else begin
              next_state = ST_REQ;
            end
          end
        end
        ST_DRAIN: begin
          if (imem_resp_valid) begin
            next_state = ST_REQ;
          end
        end
        default: next_state = ST_REQ;
      endcase
    end

    if (reset) begin
      imem_req_valid = 1'b0;
      valid_fetch    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc                <= RESET_PC;
      req_pc            <= '0;
      instruction_fetch <= DATA_WIDTH'(NOP_INSTRUCTION);
      inst_PC_fetch     <= '0;
    end else begin
      pc <= next_pc;
      if (accept) begin
        req_pc <= imem_req_addr;
      end
      if (load_fetch) begin
        instruction_fetch <= imem_resp_data;
        inst_PC_fetch     <= req_pc;
      end
    end
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that sequences instruction fetch for the out-of-order core front end. Owns the program counter, issues single-outstanding requests to the instruction memory port, and presents fetched instruction/PC/valid to the fetch pipeline register. Handles decode stall, JAL redirects from decode, and branch/trap redirects from later stages, including discarding responses that are in flight across a redirect.

## Interface
- DATA_WIDTH, 32, instruction width
- ADDRESS_BITS, 20, PC/address width
- RESET_PC, 0, first fetch address after reset
- clock  in  1  system clock
- reset  in  1  reset; synchronous, active-high; clock clock
- stall  in  1  decode cannot accept the presented instruction this cycle
- redirect_valid  in  1  branch/trap redirect from execute/commit
- redirect_target  in  ADDRESS_BITS  redirect PC
- JAL_detected  in  1  decode found a JAL; fetch restarts at jal_target
- jal_target  in  ADDRESS_BITS  JAL target PC
- imem_req_valid  out  1  request valid
- imem_req_addr  out  ADDRESS_BITS  request address
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_resp_valid  in  1  response data valid
- imem_resp_data  in  DATA_WIDTH  fetched word
- instruction_fetch  out  DATA_WIDTH  instruction to the pipe register
- inst_PC_fetch  out  ADDRESS_BITS  PC of instruction_fetch
- valid_fetch  out  1  instruction_fetch is a real instruction

## Operation
- States: REQ (request pending), WAIT (request accepted, awaiting response), HOLD (instruction held on outputs), DRAIN (discard one in-flight response).
- Event priority: reset > redirect_valid > JAL_detected > stall > normal progress.
- REQ: imem_req_valid=1, imem_req_addr=pc. On ready: latch req_pc=pc, go WAIT.
- WAIT: on imem_resp_valid: instruction_fetch<=resp_data, inst_PC_fetch<=req_pc, go HOLD.
- HOLD: valid_fetch=1. If stall: hold all outputs, no request. If !stall: instruction consumed this cycle; pc<=inst_PC_fetch+4; imem_req_valid=1 with addr inst_PC_fetch+4; ready→WAIT, else→REQ.
- Redirect/JAL in any state: pc<=target with bits[1:0] forced to 0; valid_fetch and imem_req_valid forced 0 that cycle. From WAIT, or from DRAIN with no response this cycle→DRAIN; otherwise→REQ.
- DRAIN: imem_resp_valid discarded, then→REQ. A later redirect in DRAIN only updates pc.
- Response in REQ/HOLD is a protocol error; ignored.
- PC arithmetic modulo 2^ADDRESS_BITS; all-ones wraps to 0.

## Timing
- Reset values: state=REQ, pc=RESET_PC, imem_req_valid=0 while reset is high, valid_fetch=0, instruction_fetch=0x00000013 (NOP), inst_PC_fetch=0.
- First request: cycle after reset deasserts, addr=RESET_PC.
- Outputs registered except imem_req_valid/addr and valid_fetch (state decode gated by redirect/JAL).
- Response to valid_fetch: 1 cycle. Memory with ready=1 and 1-cycle response: one instruction per 2 cycles.
- Redirect to first request at target: next cycle (not in WAIT); after drained response (in WAIT).
- Reset mid-WAIT: response arriving after reset discarded via DRAIN only if it arrives before REQ issues; memory is reset with the core.

## Structure
- Shared front-end package: NOP constant, state encoding, PC increment constant (4).
- Optional sub-module fetch_pc_select: combinational next-PC priority mux (redirect/JAL/+4/hold).

## Test plan
- Reset, RESET_PC=0x100, ready=1, 1-cycle response → requests 0x100, 0x104, 0x108; valid_fetch every 2nd cycle with matching PC.
- stall held 3 cycles in HOLD → instruction/PC stable, valid_fetch=1, no request; release → request inst_PC+4.
- redirect_valid to 0x200 during WAIT → old response dropped, valid_fetch stays 0, next request 0x200.
- redirect_valid and JAL_detected same cycle (0x300 vs 0x400) → fetch resumes at 0x300.
- imem_req_ready low 4 cycles → req_valid/addr stable; target 0xFFFFD → masked to 0xFFFFC, next 0x00000 wraps.
- reset asserted in HOLD → outputs NOP/0/valid 0; restart at RESET_PC.
